click_gen: RTL and testbench
============================

Name: click_gen

Overview:
- Button-waveform transmitter: on request, drives a single-bit `button` line with a programmable train of N press pulses (1..7).
- Each press has fixed high and low timing, followed by a quiet settle window; completion is reported with a `done` pulse.
- Serves as the stimulus source for the team's click/button detectors on-chip (self-test path) and in benches; also usable as a generic pulse-train encoder.

Parameters:
- PRESS_WIDTH, 4: cycles `button` is high per press (>=1).
- GAP_WIDTH, 3: cycles `button` is low between consecutive presses (>=1).
- SETTLE_WIDTH, 10: cycles `button` is low after the last press, before `done` (>=1).
- TIMER_WIDTH, 20: width of the internal down-timer; each *_WIDTH value must be < 2**TIMER_WIDTH.

Ports:
- clk      input   1  clock; all logic on posedge.
- rst_n    input   1  reset, synchronous, active-low.
- start    input   1  request; sampled on posedge.
- clicks   input   3  number of presses; sampled with `start`.
- button   output  1  generated waveform, registered.
- busy     output  1  high while a train is in progress.
- done     output  1  one-cycle completion pulse, registered.

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE, button=0, busy=0, done=0, timer=0, remaining=0. Takes effect at any point, including mid-press; `button` drops on that edge and no `done` is issued.
- States: IDLE, PRESS, GAP, SETTLE. busy = (state != IDLE). All outputs come from registers; no combinational input-to-output path.
- Acceptance: in IDLE, start=1 and clicks!=0 at edge E → latch remaining=clicks-1, timer=PRESS_WIDTH-1, state=PRESS. button=1 and busy=1 are visible from cycle E+1.
- Ignored requests:
  - start with clicks==0 is dropped; state stays IDLE and no done.
  - start while busy is dropped entirely; `clicks` is not re-sampled.
- PRESS: button=1. At timer==0:
  - if remaining!=0 → GAP with timer=GAP_WIDTH-1 and remaining decremented;
  - else → SETTLE with timer=SETTLE_WIDTH-1.
  - Otherwise decrement timer.
- GAP: button=0. At timer==0 → PRESS with timer=PRESS_WIDTH-1; else decrement.
- SETTLE: button=0. At timer==0 → IDLE and done=1 for exactly the next cycle (busy=0 in that same cycle); else decrement.
- A start asserted in the done cycle is accepted (IDLE), giving back-to-back trains separated only by the settle window.
- Total duration from acceptance edge E to the done cycle: N*PRESS_WIDTH + (N-1)*GAP_WIDTH + SETTLE_WIDTH + 1 cycles.
- Timer saturates at 0 and never wraps. `remaining` is 3 bits and cannot underflow because clicks>=1.

Optional Feature:
- Macro CLICK_GEN_BOUNCE_EN.
- Defined: adds parameter BOUNCE_LEN (default 2; must be < PRESS_WIDTH). During the first BOUNCE_LEN cycles of every PRESS, button follows 1,0,1,0,... starting high, then holds 1 for the rest of the press. Press duration and all other timing are unchanged.
- Undefined: button is a clean 1 for the whole press; BOUNCE_LEN and its logic do not exist.

Decomposition:
- Package click_pkg holds:
  - the state enum (IDLE, PRESS, GAP, SETTLE);
  - CLICK_CNT_W=3;
  - default timing constants shared with detector benches.
- Sub-module click_timer: loadable TIMER_WIDTH down-counter with load, load_value, and a zero flag. It is instantiated once and reloaded by the FSM.

Test Plan:
- Single click: clicks=1, start at edge 0 → button=1 in cycles 1-4, 0 from cycle 5; busy in cycles 1-14; done=1 only in cycle 15.
- Double click: clicks=2 at edge 0 → button high 1-4, low 5-7, high 8-11, low from 12; done=1 in cycle 22.
- Max count and back-to-back:
  - clicks=7 → exactly 7 rising edges on button; done in cycle 7*4+6*3+10+1=57.
  - start with clicks=1 held in cycle 57 → new press starts at cycle 58.
- Ignored requests:
  - clicks=0 with start → busy and done stay 0 for 30 cycles.
  - start with clicks=5 during busy of a clicks=1 train → still exactly one press, done in cycle 15.
- Reset mid-operation: rst_n=0 at cycle 2 of a press → button=0, busy=0 from that edge, no done; a fresh start afterwards behaves as in the single-click case.
- CLICK_GEN_BOUNCE_EN, BOUNCE_LEN=2, clicks=1 → button 1,0,1,1 in cycles 1-4; done still in cycle 15.

Source files
------------

// File: rtl/click_pkg.sv
// Shared types and default timing for the click generator and detector benches.
package click_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRESS  = 2'd1,
        GAP    = 2'd2,
        SETTLE = 2'd3
    } click_state_t;

    localparam int CLICK_CNT_W          = 3;
    localparam int DEF_PRESS_WIDTH      = 4;
    localparam int DEF_GAP_WIDTH        = 3;
    localparam int DEF_SETTLE_WIDTH     = 10;
    localparam int DEF_TIMER_WIDTH      = 20;
    localparam int DEF_BOUNCE_LEN       = 2;

    // Cycles from acceptance edge to the done cycle for an n-press train.
    function automatic int train_cycles(input int n, input int press_w,
                                        input int gap_w, input int settle_w);
        return n * press_w + (n - 1) * gap_w + settle_w + 1;
    endfunction

endpackage

// File: rtl/click_timer.sv
// Loadable saturating down-counter; the FSM reloads it on every phase change.
module click_timer #(
    parameter int WIDTH = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             zero
);

    assign zero = (count == '0);

    // Load has priority; otherwise count down and hold at zero.
    always_ff @(posedge clk) begin
        if (!rst_n)
            count <= '0;
        else if (load)
            count <= load_value;
        else if (!zero)
            count <= count - WIDTH'(1);
    end

endmodule

// File: rtl/click_gen.sv
// Button-waveform transmitter: emits N press pulses, a settle window, then a
// one-cycle done pulse. Optional contact bounce at the start of each press is
// enabled with `define CLICK_GEN_BOUNCE_EN.
module click_gen
    import click_pkg::*;
#(
    parameter int PRESS_WIDTH  = DEF_PRESS_WIDTH,
    parameter int GAP_WIDTH    = DEF_GAP_WIDTH,
    parameter int SETTLE_WIDTH = DEF_SETTLE_WIDTH,
`ifdef CLICK_GEN_BOUNCE_EN
    parameter int BOUNCE_LEN   = DEF_BOUNCE_LEN,
`endif
    parameter int TIMER_WIDTH  = DEF_TIMER_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [CLICK_CNT_W-1:0] clicks,
    output logic                   button,
    output logic                   busy,
    output logic                   done
);

    localparam logic [TIMER_WIDTH-1:0] PRESS_LOAD  = TIMER_WIDTH'(PRESS_WIDTH - 1);
    localparam logic [TIMER_WIDTH-1:0] GAP_LOAD    = TIMER_WIDTH'(GAP_WIDTH - 1);
    localparam logic [TIMER_WIDTH-1:0] SETTLE_LOAD = TIMER_WIDTH'(SETTLE_WIDTH - 1);

    click_state_t           state, state_next;
    logic [CLICK_CNT_W-1:0] remaining, remaining_next;
    logic                   load;
    logic [TIMER_WIDTH-1:0] load_value;
    logic [TIMER_WIDTH-1:0] count;
    logic                   zero;
    logic                   button_next;
    logic                   done_next;

    click_timer #(.WIDTH(TIMER_WIDTH)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .load_value (load_value),
        .count      (count),
        .zero       (zero)
    );

    assign busy = (state != IDLE);

    // Phase sequencing; timer reloads coincide with every state change.
    always_comb begin
        state_next     = state;
        remaining_next = remaining;
        load           = 1'b0;
        load_value     = '0;
        done_next      = 1'b0;
        case (state)
            IDLE: begin
                if (start && clicks != '0) begin
                    state_next     = PRESS;
                    remaining_next = clicks - CLICK_CNT_W'(1);
                    load           = 1'b1;
                    load_value     = PRESS_LOAD;
                end
            end
            PRESS: begin
                if (zero) begin
                    load = 1'b1;
                    if (remaining != '0) begin
                        state_next     = GAP;
                        remaining_next = remaining - CLICK_CNT_W'(1);
                        load_value     = GAP_LOAD;
                    end else begin
                        state_next = SETTLE;
                        load_value = SETTLE_LOAD;
                    end
                end
            end
            GAP: begin
                if (zero) begin
                    state_next = PRESS;
                    load       = 1'b1;
                    load_value = PRESS_LOAD;
                end
            end
            SETTLE: begin
                if (zero) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef CLICK_GEN_BOUNCE_EN
    // Position within the press during the next cycle: 0 on a fresh load,
    // otherwise the timer will hold count-1, i.e. PRESS_WIDTH-count elapsed.
    logic [TIMER_WIDTH-1:0] press_idx_next;

    // Press level with alternating bounce over the first BOUNCE_LEN cycles.
    always_comb begin
        press_idx_next = load ? '0 : (TIMER_WIDTH'(PRESS_WIDTH) - count);
        button_next    = (state_next == PRESS);
        if (press_idx_next < TIMER_WIDTH'(BOUNCE_LEN) && press_idx_next[0])
            button_next = 1'b0;
    end
`else
    // Clean press: line is high for the whole press phase.
    always_comb begin
        button_next = (state_next == PRESS);
    end
`endif

    // State and registered outputs; reset drops the line immediately.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            remaining <= '0;
            button    <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            remaining <= remaining_next;
            button    <= button_next;
            done      <= done_next;
        end
    end

endmodule

// File: tb/tb_click_gen.sv
// Self-checking bench for click_gen: directed scenarios plus random traffic,
// compared cycle by cycle against a timeline model of the waveform.
module tb_click_gen;

    localparam int P  = 4;
    localparam int G  = 3;
    localparam int S  = 10;
    localparam int TW = 20;
`ifdef CLICK_GEN_BOUNCE_EN
    localparam int BL = 2;
`else
    localparam int BL = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [2:0] clicks = '0;
    logic       button, busy, done;

    int checks = 0;
    int errors = 0;

    // Model: edge index of the latest accepted train (-1 = none) and its size.
    int edge_no = 0;
    int acc = -1;
    int acc_n = 0;

    click_gen #(
        .PRESS_WIDTH (P),
        .GAP_WIDTH   (G),
        .SETTLE_WIDTH(S),
`ifdef CLICK_GEN_BOUNCE_EN
        .BOUNCE_LEN  (BL),
`endif
        .TIMER_WIDTH (TW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .clicks(clicks),
        .button(button),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    function automatic int total(input int n);
        return n * P + (n - 1) * G + S + 1;
    endfunction

    // Expected {button,busy,done} in the cycle after the latest edge.
    function automatic logic [2:0] model_out();
        int k, j, off;
        logic btn;
        if (acc < 0) return 3'b000;
        k = edge_no - acc + 1;
        if (k > total(acc_n)) return 3'b000;
        if (k == total(acc_n)) return 3'b001;
        j = k - 1;
        btn = 1'b0;
        if (j < acc_n * P + (acc_n - 1) * G) begin
            off = j % (P + G);
            btn = (off < P);
            if (off < BL && (off % 2) == 1) btn = 1'b0;
        end
        return {btn, 1'b1, 1'b0};
    endfunction

    // Cycle number (1 = first cycle after acceptance) of the current cycle.
    function automatic int cyc_rel();
        return edge_no - acc + 1;
    endfunction

    // Apply inputs for one edge and advance the model; sample 1 time unit later.
    task automatic drive(input logic s, input logic [2:0] c, input logic r);
        start = s; clicks = c; rst_n = r;
        @(posedge clk);
        edge_no++;
        if (!r) acc = -1;
        else if (s && c != 0 && (acc < 0 || (edge_no - acc) >= total(acc_n))) begin
            acc = edge_no; acc_n = c;
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) drive(1'b1, 3'd3, 1'b0);
        checks++;
        if ({button, busy, done} !== 3'b000) begin
            errors++;
            $display("FAIL reset_state got %b want 000", {button, busy, done});
        end
        drive(1'b0, 3'd0, 1'b1);
    endtask

    task automatic test_single();
        int done_at = -1;
        drive(1'b1, 3'd1, 1'b1);
        for (int i = 0; i < 20; i++) begin
            checks++;
            if ({button, busy, done} !== model_out()) begin
                errors++;
                $display("FAIL single cyc %0d got %b want %b", cyc_rel(), {button, busy, done}, model_out());
            end
            if (done) done_at = cyc_rel();
            drive(1'b0, 3'd0, 1'b1);
        end
        checks++;
        if (done_at != 15) begin
            errors++;
            $display("FAIL single_done_cycle got %0d want 15", done_at);
        end
    endtask

    task automatic test_double();
        int done_at = -1;
        drive(1'b1, 3'd2, 1'b1);
        for (int i = 0; i < 26; i++) begin
            checks++;
            if ({button, busy, done} !== model_out()) begin
                errors++;
                $display("FAIL double cyc %0d got %b want %b", cyc_rel(), {button, busy, done}, model_out());
            end
            if (done) done_at = cyc_rel();
            drive(1'b0, 3'd0, 1'b1);
        end
        checks++;
        if (done_at != 22) begin
            errors++;
            $display("FAIL double_done_cycle got %0d want 22", done_at);
        end
    endtask

    task automatic test_back_to_back();
        int rises = 0;
        int done_at = -1;
        logic prev = 1'b0;
        int first_acc;
        drive(1'b1, 3'd7, 1'b1);
        first_acc = acc;
        for (int i = 0; i < 57; i++) begin
            checks++;
            if ({button, busy, done} !== model_out()) begin
                errors++;
                $display("FAIL max7 cyc %0d got %b want %b", cyc_rel(), {button, busy, done}, model_out());
            end
            if (button && !prev) rises++;
            prev = button;
            if (done && done_at < 0) done_at = edge_no - first_acc + 1;
            // Request held in the done cycle (cycle 57) must be taken.
            drive(i == 56, 3'd1, 1'b1);
        end
        checks++;
        if (rises != 7 * (1 + BL / 2) || done_at != 57) begin
            errors++;
            $display("FAIL max7_summary rises %0d done %0d want rises %0d done 57", rises, done_at, 7 * (1 + BL / 2));
        end
        checks++;
        if (acc != first_acc + 57 || button !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL back_to_back cyc58 button %b busy %b want 1 1", button, busy);
        end
        for (int i = 0; i < 16; i++) drive(1'b0, 3'd0, 1'b1);
    endtask

    task automatic test_ignored();
        int seen = 0;
        for (int i = 0; i < 30; i++) begin
            drive(1'b1, 3'd0, 1'b1);
            if (busy || done) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL zero_clicks active cycles %0d want 0", seen);
        end
        drive(1'b1, 3'd1, 1'b1);
        for (int i = 0; i < 20; i++) begin
            checks++;
            if ({button, busy, done} !== model_out()) begin
                errors++;
                $display("FAIL busy_ignore cyc %0d got %b want %b", cyc_rel(), {button, busy, done}, model_out());
            end
            drive(i < 8, 3'd5, 1'b1);
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 3'd3, 1'b1);
        drive(1'b0, 3'd0, 1'b1);
        drive(1'b0, 3'd0, 1'b0);
        for (int i = 0; i < 25; i++) begin
            checks++;
            if ({button, busy, done} !== 3'b000) begin
                errors++;
                $display("FAIL reset_mid cyc %0d got %b want 000", i, {button, busy, done});
            end
            drive(1'b0, 3'd0, 1'b1);
        end
        test_single();
    endtask

    task automatic test_random();
        logic s, r;
        logic [2:0] c;
        for (int i = 0; i < 1500; i++) begin
            s = ($urandom_range(0, 5) == 0);
            c = 3'($urandom_range(0, 7));
            r = ($urandom_range(0, 299) != 0);
            drive(s, c, r);
            checks++;
            if ({button, busy, done} !== model_out()) begin
                errors++;
                $display("FAIL random edge %0d got %b want %b", edge_no, {button, busy, done}, model_out());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_double();
        test_back_to_back();
        test_ignored();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
